soc1_key_edge_pio: RTL and testbench
====================================

# soc1_key_edge_pio

Parametrised Avalon-MM input PIO for push-button and switch inputs, the successor to the fixed 2-bit key port in the soc1 system. It synchronises WIDTH asynchronous input pins, debounces each bit independently, captures selected edges into sticky bits, and raises a maskable level interrupt to the Nios II processor. It sits on the soc1 Avalon-MM interconnect as a slave with a 32-bit data bus and a 3-bit word address.

## Interface
- WIDTH, 2: number of input bits, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable clocks required to accept a new level, ≥1. Counter width is $clog2(DEBOUNCE_CYCLES+1).
- EDGE_TYPE, 1: edge to capture. 0 = rising, 1 = falling, 2 = any.
- RESET_LEVEL, all ones: reset value of the debounced state. Keys are active-low, so idle is high.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select; qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH are ignored.
- in_port  in  WIDTH  asynchronous input pins.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map:
  - Address 0, DATA: read-only debounced state. Writes are ignored.
  - Address 2, IRQMASK: read/write, WIDTH bits.
  - Address 3, EDGECAPTURE: read returns the sticky bits. A write clears every bit set in writedata (write-1-to-clear).
  - Addresses 1 and 4–7 read 0; writes to them are ignored.
- Write accepted when chipselect=1 and write_n=0. Reads need no strobe: readdata follows address every cycle.
- Input path per bit: sync1 → sync2 (two-flop synchroniser) → debouncer → stable → prev.
- Debouncer, per bit:
  - If sync2 ≠ stable, the counter increments.
  - If the counter = DEBOUNCE_CYCLES−1 and sync2 still ≠ stable, then stable ← sync2 and the counter ← 0.
  - If sync2 = stable, the counter ← 0. A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
- Edge detect: prev ← stable every clock.
  - Rising edge = stable & ~prev.
  - Falling edge = ~stable & prev.
  - Any edge = XOR of the two.
- EDGECAPTURE bit sets when its edge is detected and stays set until cleared. If a set and a write-1 clear land on the same cycle, the set wins.
- irq = |(EDGECAPTURE & IRQMASK). It is combinational from registers and adds no latency beyond theirs.

## Timing
- Reset values:
  - readdata = 0, irq = 0, IRQMASK = 0, EDGECAPTURE = 0.
  - sync1 = sync2 = stable = prev = RESET_LEVEL; counters = 0.
- Reset asserted mid-debounce or with edges pending discards all state. No edge is generated on reset exit if the inputs equal RESET_LEVEL.
- in_port change sampled at edge k:
  - sync2 changes at k+1.
  - stable changes at k+1+DEBOUNCE_CYCLES.
  - EDGECAPTURE and irq change at k+2+DEBOUNCE_CYCLES.
- Read latency: 1 clock. readdata at edge n+1 reflects the address and register contents present at edge n.
- A write takes effect on the edge it is sampled. A read of the same register in the following cycle returns the new value.
- Counters never wrap: the maximum count is DEBOUNCE_CYCLES−1, after which the counter resets to 0.

## Configuration
- SOC1_KEY_DEBOUNCE_EN defined: the debouncer is instantiated as described above.
- SOC1_KEY_DEBOUNCE_EN undefined: no counters are built. stable ← sync2 every clock, DEBOUNCE_CYCLES is ignored, and in_port→stable latency is 2 clocks.

## Test plan
- Reset with in_port=2'b11, then read address 0 → readdata=0x3, EDGECAPTURE=0, irq=0.
- DEBOUNCE_CYCLES=8, in_port[0] low for 5 clocks then high → DATA stays 0x3 and EDGECAPTURE stays 0.
- in_port[1] held low for 20 clocks with IRQMASK=0x2 → DATA=0x1 at k+9, EDGECAPTURE=0x2 and irq=1 at k+10.
- Write 0x2 to address 3 on the same cycle a new falling edge on bit 1 is detected → EDGECAPTURE stays 0x2 and irq stays 1. A later clear with no new edge → 0, irq=0.
- EDGECAPTURE=0x1 with IRQMASK=0 → irq=0. Write IRQMASK=0x1 → irq=1 the next clock. Reading address 5 → 0.
- Assert reset mid-debounce with EDGECAPTURE=0x3 → all registers at reset values the next clock. No edge is captured after release while inputs stay high.

Source files
------------

// File: rtl/soc1_key_edge_pio_if.sv
// Avalon-MM slave bus for soc1_key_edge_pio: 3-bit word address, 32-bit data, level irq.
interface soc1_key_edge_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/soc1_key_edge_pio.sv
// Input PIO for keys/switches: sync, per-bit debounce, sticky edge capture, maskable irq.
// Define SOC1_KEY_DEBOUNCE_EN to build the debounce counters; otherwise stable follows sync2.
module soc1_key_edge_pio_lane #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic edge_o
);
  logic sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, prev_q, prev_d;
  logic rise, fall;

`ifdef SOC1_KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      // accept on the DEBOUNCE_CYCLES-th consecutive disagreeing clock
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
      else                                    cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  always_comb stable_d = sync2_q;
`endif

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    prev_d  = stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= RESET_LEVEL;
      sync2_q  <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      prev_q   <= RESET_LEVEL;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
    end
  end

  assign rise   = stable_q & ~prev_q;
  assign fall   = ~stable_q & prev_q;
  assign edge_o = (EDGE_TYPE == 0) ? rise : (EDGE_TYPE == 1) ? fall : (rise ^ fall);
  assign stable = stable_q;
endmodule

module soc1_key_edge_pio #(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  soc1_key_edge_pio_if.slave    bus,
  input  logic [WIDTH-1:0]      in_port
);
  logic [WIDTH-1:0] stable, edges, clr;
  logic [WIDTH-1:0] mask_q, mask_d, ecap_q, ecap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    soc1_key_edge_pio_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_TYPE       (EDGE_TYPE),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pin    (in_port[i]),
      .stable (stable[i]),
      .edge_o (edges[i])
    );
  end

  assign wr = bus.chipselect & ~bus.write_n;

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr && bus.address == 3'd2) mask_d = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == 3'd3) clr    = bus.writedata[WIDTH-1:0];
    // a new edge beats a simultaneous write-1-to-clear
    ecap_d = (ecap_q & ~clr) | edges;
    rdata_d = '0;
    case (bus.address)
      3'd0:    rdata_d[WIDTH-1:0] = stable;
      3'd2:    rdata_d[WIDTH-1:0] = mask_q;
      3'd3:    rdata_d[WIDTH-1:0] = ecap_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      ecap_q  <= '0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      ecap_q  <= ecap_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign bus.irq      = |(ecap_q & mask_q);
endmodule

// File: tb/tb_soc1_key_edge_pio.sv
// Bench for soc1_key_edge_pio: window-based reference model checked every cycle, plus literal checks.
module tb_soc1_key_edge_pio;
  localparam int         W  = 2;
  localparam int         D  = 8;
  localparam int         ET = 1;
  localparam logic [1:0] RL = 2'b11;
`ifdef SOC1_KEY_DEBOUNCE_EN
  localparam int LAT = D + 2;   // in_port edge k -> EDGECAPTURE at k+LAT
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_port;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         model_ok = 1'b0;

  soc1_key_edge_pio_if bus ();

  soc1_key_edge_pio #(
    .WIDTH (W), .DEBOUNCE_CYCLES (D), .EDGE_TYPE (ET), .RESET_LEVEL (RL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stable flips once sync2 has disagreed with it for the last D clocks.
  logic [W-1:0] m_s1, m_s2, m_st, m_pv, m_ec, m_mk;
  logic [31:0]  m_rd;
  logic [W-1:0] hist[$];

  always @(posedge clk) begin : model
    logic [W-1:0] n_st, clr, edg, rise, fall;
    logic         disagree;
    if (reset) begin
      m_s1 = RL; m_s2 = RL; m_st = RL; m_pv = RL;
      m_ec = '0; m_mk = '0; m_rd = '0;
      hist = {};
      model_ok = 1'b1;
    end else begin
      case (bus.address)
        3'd0:    m_rd = {30'b0, m_st};
        3'd2:    m_rd = {30'b0, m_mk};
        3'd3:    m_rd = {30'b0, m_ec};
        default: m_rd = '0;
      endcase
      rise = m_st & ~m_pv;
      fall = ~m_st & m_pv;
      edg  = (ET == 0) ? rise : (ET == 1) ? fall : (rise | fall);
`ifdef SOC1_KEY_DEBOUNCE_EN
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      n_st = m_st;
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          disagree = 1'b1;
          foreach (hist[j]) if (hist[j][b] == m_st[b]) disagree = 1'b0;
          if (disagree) n_st[b] = ~m_st[b];
        end
      end
`else
      disagree = 1'b0;
      n_st = m_s2;
`endif
      clr = '0;
      if (bus.chipselect && !bus.write_n) begin
        if (bus.address == 3'd2) m_mk = bus.writedata[W-1:0];
        if (bus.address == 3'd3) clr  = bus.writedata[W-1:0];
      end
      m_ec = (m_ec & ~clr) | edg;
      m_pv = m_st;
      m_st = n_st;
      m_s2 = m_s1;
      m_s1 = in_port;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("readdata_model", bus.readdata, m_rd);
      chk("irq_model", {31'b0, bus.irq}, {31'b0, |(m_ec & m_mk)});
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    bus.address = a;
    @(negedge clk);
    v = bus.readdata;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; in_port = 2'b11;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (2) @(negedge clk);
    chk("rd_in_reset", bus.readdata, 32'h0);
    chk("irq_in_reset", {31'b0, bus.irq}, 32'h0);
    reset = 1'b0;
    rd(3'd0, v); chk("reset_data", v, 32'h3);
    rd(3'd3, v); chk("reset_ecap", v, 32'h0);
    chk("reset_irq", {31'b0, bus.irq}, 32'h0);

    // 5-clock glitch on bit 0
    in_port = 2'b10;
    repeat (5) @(negedge clk);
    in_port = 2'b11;
    repeat (20) @(negedge clk);
    rd(3'd0, v); chk("glitch_data", v, 32'h3);
    rd(3'd3, v);
`ifdef SOC1_KEY_DEBOUNCE_EN
    chk("glitch_ecap", v, 32'h0);
`else
    chk("glitch_ecap", v, 32'h1);
`endif
    wr(3'd3, 32'h3);

    // held press on bit 1 with mask 0x2: exact latency
    wr(3'd2, 32'h2);
    bus.address = 3'd0;
    in_port = 2'b01;
    repeat (LAT) @(negedge clk);
    chk("press_data_before", bus.readdata, 32'h3);
    chk("press_irq_before", {31'b0, bus.irq}, 32'h0);
    @(negedge clk);
    chk("press_data_after", bus.readdata, 32'h1);
    chk("press_irq_after", {31'b0, bus.irq}, 32'h1);
    repeat (12) @(negedge clk);
    rd(3'd3, v); chk("press_ecap", v, 32'h2);

    // clear lands on the same edge as a new falling-edge set
    in_port = 2'b11;
    repeat (20) @(negedge clk);
    in_port = 2'b01;
    repeat (LAT) @(negedge clk);
    wr(3'd3, 32'h2);
    rd(3'd3, v); chk("race_ecap", v, 32'h2);
    chk("race_irq", {31'b0, bus.irq}, 32'h1);
    wr(3'd3, 32'h2);
    rd(3'd3, v); chk("clear_ecap", v, 32'h0);
    chk("clear_irq", {31'b0, bus.irq}, 32'h0);

    // captured bit 0 with mask 0, then unmask
    wr(3'd2, 32'h0);
    in_port = 2'b00;
    repeat (20) @(negedge clk);
    rd(3'd3, v); chk("masked_ecap", v, 32'h1);
    chk("masked_irq", {31'b0, bus.irq}, 32'h0);
    wr(3'd2, 32'h1);
    chk("unmask_irq", {31'b0, bus.irq}, 32'h1);
    rd(3'd5, v); chk("addr5", v, 32'h0);
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, v); chk("addr1", v, 32'h0);
    rd(3'd2, v); chk("mask_rb", v, 32'h1);

    // reset mid-debounce with both capture bits set
    in_port = 2'b11;
    repeat (20) @(negedge clk);
    in_port = 2'b00;
    repeat (20) @(negedge clk);
    rd(3'd3, v); chk("pre_reset_ecap", v, 32'h3);
    in_port = 2'b11;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_rd", bus.readdata, 32'h0);
    chk("mid_reset_irq", {31'b0, bus.irq}, 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    rd(3'd3, v); chk("post_reset_ecap", v, 32'h0);
    rd(3'd2, v); chk("post_reset_mask", v, 32'h0);
    wr(3'd0, 32'h0);
    rd(3'd0, v); chk("post_reset_data", v, 32'h3);
    chk("post_reset_irq", {31'b0, bus.irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
